bin_to_bcd_seq: RTL



---
 rtl/bin_to_bcd_seq_pkg.sv | 16 +
 rtl/bin_to_bcd_seq_if.sv | 17 +
 rtl/bin_to_bcd_seq_digit_adj.sv | 10 +
 rtl/bin_to_bcd_seq.sv | 122 ++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {IDLE, SHIFT} bcd_state_t;

  localparam int BCD_NIBBLE_W = 4;

  // Largest value representable with n_digits decimal digits (10**n - 1).
  function automatic int max_val(input int n_digits);
    int r;
    r = 1;
    for (int i = 0; i < n_digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus between a requester and the converter.
interface bin_to_bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int N_BITS   = 14,
  parameter int N_DIGITS = 4
);
  logic                             start;
  logic [N_BITS-1:0]                bin_in;
  logic                             busy;
  logic                             done;
  logic [BCD_NIBBLE_W*N_DIGITS-1:0] bcd_out;
  logic                             overflow;

  modport master (output start, bin_in, input busy, done, bcd_out, overflow);
  modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);
endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Single-digit add-3 adjust used before each shift of the double-dabble loop.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  // A digit of 5..9 would exceed 9 after doubling, so pre-add 3 (result <= 12 fits the nibble).
  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock.
// Values above the decimal range saturate to all-nines with overflow set.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int N_BITS   = 14,
  parameter int N_DIGITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  bin_to_bcd_seq_if.slave  bus
);
  localparam int SCR_W   = BCD_NIBBLE_W * N_DIGITS;
  localparam int CNT_W   = $clog2(N_BITS + 1);
  localparam int MAX_VAL = max_val(N_DIGITS);
  localparam int IN_MAX  = (1 << N_BITS) - 1;
  // When the input cannot exceed the decimal range, clamp the threshold so it never trips.
  localparam logic [N_BITS:0]  MAX_CMP  = (N_BITS + 1)'((MAX_VAL > IN_MAX) ? IN_MAX : MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);
  localparam logic [SCR_W-1:0] SAT_BCD  = {N_DIGITS{4'h9}};

  // Saturation is always present, so any input width is safe; only reject degenerate sizes.
  if (N_BITS < 1 || N_BITS > 30 || N_DIGITS < 1) begin : g_bad_cfg
    $error("bin_to_bcd_seq: unsupported N_BITS/N_DIGITS");
  end

  bcd_state_t          state_q, state_d;
  logic [N_BITS-1:0]   shreg_q, shreg_d;
  logic [SCR_W-1:0]    scr_q, scr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [SCR_W-1:0]    bcd_q, bcd_d;
  logic                ovf_q, ovf_d;

  logic [SCR_W-1:0]    adj;
  logic [SCR_W-1:0]    scr_sh;
  logic [N_BITS-1:0]   shreg_sh;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scr_q[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .dout (adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end

  // Adjusted scratch and binary shift register move left together by one bit.
  always_comb begin
    scr_sh   = {adj[SCR_W-2:0], shreg_q[N_BITS-1]};
    shreg_sh = {shreg_q[N_BITS-2:0], 1'b0};
  end

  // Next-state logic: capture on start in IDLE, shift N_BITS times, then publish the result.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d    = bus.bin_in;
          scr_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = ({1'b0, bus.bin_in} > MAX_CMP);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d    = shreg_sh;
        scr_d      = scr_sh;
        cnt_d      = cnt_q + 1'b1;
        // A digit carried out of the top nibble also means the value did not fit.
        ovf_pend_d = ovf_pend_q | adj[SCR_W-1];
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bcd_d   = ovf_pend_d ? SAT_BCD : scr_sh;
          ovf_d   = ovf_pend_d;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

  // All state and registered outputs; reset abandons any conversion in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule
